controller_top: RTL and testbench

CONTROLLER_TOP -- requirements
Module: Controller

---
 rtl/controller_pkg.sv | 18 +
 rtl/controller_port.sv | 197 +++++++++++++++++++
 rtl/controller_top.sv | 90 +++++++++
 tb/tb_controller_top.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared types and defaults for the opcode-driven AXI-style controller.
package controller_pkg;

   localparam int unsigned FIFO_DEPTH_DEFAULT = 4;
   localparam int unsigned BURST_LEN_DEFAULT  = 4;

   typedef enum logic [1:0] {
      TgtNone = 2'b00,
      TgtAlu  = 2'b01,
      TgtMem  = 2'b10,
      TgtIo   = 2'b11
   } target_e;

   typedef enum logic [1:0] {RdIdle, RdAr, RdR} rd_state_e;

   typedef enum logic [1:0] {WrIdle, WrAw, WrW, WrB} wr_state_e;

endpackage

// File: rtl/controller_port.sv
// One slave port: read/write ID queues plus independent read and write burst FSMs.
// Optional CTRL_ID_CHECK_EN flags a write response whose BID differs from the issued AWID.
module controller_port
   import controller_pkg::*;
#(
   parameter int unsigned FifoDepth = FIFO_DEPTH_DEFAULT,
   parameter int unsigned BurstLen  = BURST_LEN_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rd_push_i,
   input  logic        wr_push_i,
   input  logic [3:0]  push_id_i,
   input  logic [8:0]  in_i,
   input  logic        arready_i,
   input  logic        rvalid_i,
   input  logic        rlast_i,
   input  logic        awready_i,
   input  logic        wready_i,
   input  logic        bvalid_i,
   input  logic [4:0]  bresp_i,
   input  logic        ridle_i,
   input  logic        widle_i,
   input  logic        ridle_prev_i,
   input  logic        widle_prev_i,
   output logic        arvalid_o,
   output logic        rready_o,
   output logic        awvalid_o,
   output logic        wvalid_o,
   output logic        wlast_o,
   output logic        bready_o,
   output logic [15:0] out_o,
   output logic [11:0] awout_o,
   output logic [7:0]  wdata_o,
   output logic [7:0]  rdata_o,
   output logic        rresp_o,
   output logic [4:0]  bout_o
);

   localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int unsigned CntW = $clog2(FifoDepth + 1);
   localparam logic [3:0]  LastBeat = 4'(BurstLen - 1);

   logic [3:0]      rq_mem_q [FifoDepth];
   logic [3:0]      wq_mem_q [FifoDepth];
   logic [PtrW-1:0] rq_wp_q, rq_wp_d, rq_rp_q, rq_rp_d;
   logic [PtrW-1:0] wq_wp_q, wq_wp_d, wq_rp_q, wq_rp_d;
   logic [CntW-1:0] rq_cnt_q, rq_cnt_d, wq_cnt_q, wq_cnt_d;
   logic            rq_push, rq_pop, wq_push, wq_pop;

   rd_state_e  rd_state_q, rd_state_d;
   wr_state_e  wr_state_q, wr_state_d;
   logic [3:0] arid_q, arid_d, awid_q, awid_d, beat_q, beat_d;
   logic [7:0] rdata_q, rdata_d;
   logic       rresp_q, rresp_d;
   logic [4:0] bout_q, bout_d;

   // A push into a full queue is dropped even if the same edge pops.
   assign rq_push = rd_push_i && (rq_cnt_q != CntW'(FifoDepth));
   assign wq_push = wr_push_i && (wq_cnt_q != CntW'(FifoDepth));

   always_comb begin
      rq_wp_d  = rq_push ? rq_wp_q + PtrW'(1) : rq_wp_q;
      rq_rp_d  = rq_pop  ? rq_rp_q + PtrW'(1) : rq_rp_q;
      wq_wp_d  = wq_push ? wq_wp_q + PtrW'(1) : wq_wp_q;
      wq_rp_d  = wq_pop  ? wq_rp_q + PtrW'(1) : wq_rp_q;
      rq_cnt_d = rq_cnt_q + CntW'(rq_push) - CntW'(rq_pop);
      wq_cnt_d = wq_cnt_q + CntW'(wq_push) - CntW'(wq_pop);
   end

   always_comb begin
      rd_state_d = rd_state_q;
      arid_d     = arid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      rq_pop     = 1'b0;
      arvalid_o  = 1'b0;
      rready_o   = 1'b0;
      unique case (rd_state_q)
         RdIdle: begin
            if (rq_cnt_q != '0 && ridle_i && ridle_prev_i) begin
               rq_pop     = 1'b1;
               arid_d     = rq_mem_q[rq_rp_q];
               rd_state_d = RdAr;
            end
         end
         RdAr: begin
            arvalid_o = 1'b1;
            if (arready_i) rd_state_d = RdR;
         end
         RdR: begin
            rready_o = 1'b1;
            if (rvalid_i) begin
               rdata_d = in_i[7:0];
               rresp_d = in_i[8];
               if (rlast_i) rd_state_d = RdIdle;
            end
         end
         default: rd_state_d = RdIdle;
      endcase
   end

   always_comb begin
      wr_state_d = wr_state_q;
      awid_d     = awid_q;
      beat_d     = beat_q;
      bout_d     = bout_q;
      wq_pop     = 1'b0;
      awvalid_o  = 1'b0;
      wvalid_o   = 1'b0;
      bready_o   = 1'b0;
      unique case (wr_state_q)
         WrIdle: begin
            if (wq_cnt_q != '0 && widle_i && widle_prev_i) begin
               wq_pop     = 1'b1;
               awid_d     = wq_mem_q[wq_rp_q];
               wr_state_d = WrAw;
            end
         end
         WrAw: begin
            awvalid_o = 1'b1;
            if (awready_i) begin
               beat_d     = '0;
               wr_state_d = WrW;
            end
         end
         WrW: begin
            wvalid_o = 1'b1;
            if (wready_i) begin
               if (beat_q == LastBeat) wr_state_d = WrB;
               else beat_d = beat_q + 4'd1;
            end
         end
         WrB: begin
            bready_o = 1'b1;
            if (bvalid_i) begin
               bout_d = bresp_i;
`ifdef CTRL_ID_CHECK_EN
               bout_d[0] = bresp_i[0] | (bresp_i[4:1] != awid_q);
`endif
               wr_state_d = WrIdle;
            end
         end
         default: wr_state_d = WrIdle;
      endcase
   end

   // Address/data buses are zero outside their phase so reset and idle look identical.
   assign out_o   = (rd_state_q == RdAr) ? {arid_q, LastBeat, arid_q, 4'h0} : '0;
   assign awout_o = (wr_state_q == WrAw) ? {awid_q, awid_q, 4'h0} : '0;
   assign wdata_o = (wr_state_q == WrW) ? {awid_q, beat_q} : '0;
   assign wlast_o = (wr_state_q == WrW) && (beat_q == LastBeat);
   assign rdata_o = rdata_q;
   assign rresp_o = rresp_q;
   assign bout_o  = bout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FifoDepth); i++) begin
            rq_mem_q[i] <= '0;
            wq_mem_q[i] <= '0;
         end
         rq_wp_q    <= '0;
         rq_rp_q    <= '0;
         wq_wp_q    <= '0;
         wq_rp_q    <= '0;
         rq_cnt_q   <= '0;
         wq_cnt_q   <= '0;
         rd_state_q <= RdIdle;
         wr_state_q <= WrIdle;
         arid_q     <= '0;
         awid_q     <= '0;
         beat_q     <= '0;
         rdata_q    <= '0;
         rresp_q    <= 1'b0;
         bout_q     <= '0;
      end else begin
         if (rq_push) rq_mem_q[rq_wp_q] <= push_id_i;
         if (wq_push) wq_mem_q[wq_wp_q] <= push_id_i;
         rq_wp_q    <= rq_wp_d;
         rq_rp_q    <= rq_rp_d;
         wq_wp_q    <= wq_wp_d;
         wq_rp_q    <= wq_rp_d;
         rq_cnt_q   <= rq_cnt_d;
         wq_cnt_q   <= wq_cnt_d;
         rd_state_q <= rd_state_d;
         wr_state_q <= wr_state_d;
         arid_q     <= arid_d;
         awid_q     <= awid_d;
         beat_q     <= beat_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         bout_q     <= bout_d;
      end
   end

endmodule

// File: rtl/controller_top.sv
// Opcode decoder fanning commands out to three concurrent slave ports (ALU, MEM, IO).
// Build with CTRL_ID_CHECK_EN defined to enable write-response ID checking.
module controller_top
   import controller_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
   parameter int unsigned BURST_LEN  = BURST_LEN_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [7:0]  opcode,
   input  logic [8:0]  ALU_IN, MEM_IN, IO_IN,
   input  logic        ALU_ARREADY, ALU_RVALID, ALU_RLAST, ALU_AWREADY, ALU_WREADY, ALU_BVALID,
   input  logic        MEM_ARREADY, MEM_RVALID, MEM_RLAST, MEM_AWREADY, MEM_WREADY, MEM_BVALID,
   input  logic        IO_ARREADY, IO_RVALID, IO_RLAST, IO_AWREADY, IO_WREADY, IO_BVALID,
   input  logic [4:0]  ALU_BRESP, MEM_BRESP, IO_BRESP,
   input  logic        ALU_RIDLE, ALU_WIDLE, ALU_RIDLE_prev, ALU_WIDLE_prev,
   input  logic        MEM_RIDLE, MEM_WIDLE, MEM_RIDLE_prev, MEM_WIDLE_prev,
   input  logic        IO_RIDLE, IO_WIDLE, IO_RIDLE_prev, IO_WIDLE_prev,
   output logic        ALU_ARVALID, ALU_RREADY, ALU_AWVALID, ALU_WVALID, ALU_WLAST, ALU_BREADY,
   output logic        MEM_ARVALID, MEM_RREADY, MEM_AWVALID, MEM_WVALID, MEM_WLAST, MEM_BREADY,
   output logic        IO_ARVALID, IO_RREADY, IO_AWVALID, IO_WVALID, IO_WLAST, IO_BREADY,
   output logic [15:0] ALU_OUT, MEM_OUT, IO_OUT,
   output logic [11:0] ALU_AWOUT, MEM_AWOUT, IO_AWOUT,
   output logic [7:0]  ALU_WDATA, MEM_WDATA, IO_WDATA,
   output logic [7:0]  ALU_RDATA, MEM_RDATA, IO_RDATA,
   output logic        ALU_RRESP, MEM_RRESP, IO_RRESP,
   output logic [4:0]  ALU_BOUT, MEM_BOUT, IO_BOUT
);

   target_e    tgt;
   logic [3:0] push_id;
   logic [2:0] rd_push, wr_push;
   logic       unused_reserved;

   assign tgt             = target_e'(opcode[3:2]);
   assign push_id         = opcode[7:4];
   assign unused_reserved = opcode[0];

   always_comb begin
      rd_push = '0;
      wr_push = '0;
      if (en) begin
         unique case (tgt)
            TgtAlu:  begin rd_push[0] = ~opcode[1]; wr_push[0] = opcode[1]; end
            TgtMem:  begin rd_push[1] = ~opcode[1]; wr_push[1] = opcode[1]; end
            TgtIo:   begin rd_push[2] = ~opcode[1]; wr_push[2] = opcode[1]; end
            default: ;
         endcase
      end
   end

   controller_port #(.FifoDepth(FIFO_DEPTH), .BurstLen(BURST_LEN)) u_alu (
      .clk(clk), .rst_n(rst), .rd_push_i(rd_push[0]), .wr_push_i(wr_push[0]),
      .push_id_i(push_id), .in_i(ALU_IN), .arready_i(ALU_ARREADY), .rvalid_i(ALU_RVALID),
      .rlast_i(ALU_RLAST), .awready_i(ALU_AWREADY), .wready_i(ALU_WREADY),
      .bvalid_i(ALU_BVALID), .bresp_i(ALU_BRESP), .ridle_i(ALU_RIDLE), .widle_i(ALU_WIDLE),
      .ridle_prev_i(ALU_RIDLE_prev), .widle_prev_i(ALU_WIDLE_prev),
      .arvalid_o(ALU_ARVALID), .rready_o(ALU_RREADY), .awvalid_o(ALU_AWVALID),
      .wvalid_o(ALU_WVALID), .wlast_o(ALU_WLAST), .bready_o(ALU_BREADY), .out_o(ALU_OUT),
      .awout_o(ALU_AWOUT), .wdata_o(ALU_WDATA), .rdata_o(ALU_RDATA), .rresp_o(ALU_RRESP),
      .bout_o(ALU_BOUT)
   );

   controller_port #(.FifoDepth(FIFO_DEPTH), .BurstLen(BURST_LEN)) u_mem (
      .clk(clk), .rst_n(rst), .rd_push_i(rd_push[1]), .wr_push_i(wr_push[1]),
      .push_id_i(push_id), .in_i(MEM_IN), .arready_i(MEM_ARREADY), .rvalid_i(MEM_RVALID),
      .rlast_i(MEM_RLAST), .awready_i(MEM_AWREADY), .wready_i(MEM_WREADY),
      .bvalid_i(MEM_BVALID), .bresp_i(MEM_BRESP), .ridle_i(MEM_RIDLE), .widle_i(MEM_WIDLE),
      .ridle_prev_i(MEM_RIDLE_prev), .widle_prev_i(MEM_WIDLE_prev),
      .arvalid_o(MEM_ARVALID), .rready_o(MEM_RREADY), .awvalid_o(MEM_AWVALID),
      .wvalid_o(MEM_WVALID), .wlast_o(MEM_WLAST), .bready_o(MEM_BREADY), .out_o(MEM_OUT),
      .awout_o(MEM_AWOUT), .wdata_o(MEM_WDATA), .rdata_o(MEM_RDATA), .rresp_o(MEM_RRESP),
      .bout_o(MEM_BOUT)
   );

   controller_port #(.FifoDepth(FIFO_DEPTH), .BurstLen(BURST_LEN)) u_io (
      .clk(clk), .rst_n(rst), .rd_push_i(rd_push[2]), .wr_push_i(wr_push[2]),
      .push_id_i(push_id), .in_i(IO_IN), .arready_i(IO_ARREADY), .rvalid_i(IO_RVALID),
      .rlast_i(IO_RLAST), .awready_i(IO_AWREADY), .wready_i(IO_WREADY),
      .bvalid_i(IO_BVALID), .bresp_i(IO_BRESP), .ridle_i(IO_RIDLE), .widle_i(IO_WIDLE),
      .ridle_prev_i(IO_RIDLE_prev), .widle_prev_i(IO_WIDLE_prev),
      .arvalid_o(IO_ARVALID), .rready_o(IO_RREADY), .awvalid_o(IO_AWVALID),
      .wvalid_o(IO_WVALID), .wlast_o(IO_WLAST), .bready_o(IO_BREADY), .out_o(IO_OUT),
      .awout_o(IO_AWOUT), .wdata_o(IO_WDATA), .rdata_o(IO_RDATA), .rresp_o(IO_RRESP),
      .bout_o(IO_BOUT)
   );

endmodule

// File: tb/tb_controller_top.sv
// Directed bench for controller_top; slave index 0=ALU, 1=MEM, 2=IO.
module tb_controller_top;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic [7:0] opcode;

   logic [8:0]  s_in [3];
   logic [4:0]  s_bresp [3];
   logic [2:0]  arready, rvalid, rlast, awready, wready, bvalid;
   logic [2:0]  ridle, widle, ridle_prev, widle_prev;
   logic [2:0]  arvalid, rready, awvalid, wvalid, wlast, bready, rresp;
   logic [15:0] out_s [3];
   logic [11:0] awout_s [3];
   logic [7:0]  wdata_s [3];
   logic [7:0]  rdata_s [3];
   logic [4:0]  bout_s [3];

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   controller_top dut (
      .clk(clk), .rst(rst), .en(en), .opcode(opcode),
      .ALU_IN(s_in[0]), .MEM_IN(s_in[1]), .IO_IN(s_in[2]),
      .ALU_ARREADY(arready[0]), .ALU_RVALID(rvalid[0]), .ALU_RLAST(rlast[0]),
      .ALU_AWREADY(awready[0]), .ALU_WREADY(wready[0]), .ALU_BVALID(bvalid[0]),
      .MEM_ARREADY(arready[1]), .MEM_RVALID(rvalid[1]), .MEM_RLAST(rlast[1]),
      .MEM_AWREADY(awready[1]), .MEM_WREADY(wready[1]), .MEM_BVALID(bvalid[1]),
      .IO_ARREADY(arready[2]), .IO_RVALID(rvalid[2]), .IO_RLAST(rlast[2]),
      .IO_AWREADY(awready[2]), .IO_WREADY(wready[2]), .IO_BVALID(bvalid[2]),
      .ALU_BRESP(s_bresp[0]), .MEM_BRESP(s_bresp[1]), .IO_BRESP(s_bresp[2]),
      .ALU_RIDLE(ridle[0]), .ALU_WIDLE(widle[0]),
      .ALU_RIDLE_prev(ridle_prev[0]), .ALU_WIDLE_prev(widle_prev[0]),
      .MEM_RIDLE(ridle[1]), .MEM_WIDLE(widle[1]),
      .MEM_RIDLE_prev(ridle_prev[1]), .MEM_WIDLE_prev(widle_prev[1]),
      .IO_RIDLE(ridle[2]), .IO_WIDLE(widle[2]),
      .IO_RIDLE_prev(ridle_prev[2]), .IO_WIDLE_prev(widle_prev[2]),
      .ALU_ARVALID(arvalid[0]), .ALU_RREADY(rready[0]), .ALU_AWVALID(awvalid[0]),
      .ALU_WVALID(wvalid[0]), .ALU_WLAST(wlast[0]), .ALU_BREADY(bready[0]),
      .MEM_ARVALID(arvalid[1]), .MEM_RREADY(rready[1]), .MEM_AWVALID(awvalid[1]),
      .MEM_WVALID(wvalid[1]), .MEM_WLAST(wlast[1]), .MEM_BREADY(bready[1]),
      .IO_ARVALID(arvalid[2]), .IO_RREADY(rready[2]), .IO_AWVALID(awvalid[2]),
      .IO_WVALID(wvalid[2]), .IO_WLAST(wlast[2]), .IO_BREADY(bready[2]),
      .ALU_OUT(out_s[0]), .MEM_OUT(out_s[1]), .IO_OUT(out_s[2]),
      .ALU_AWOUT(awout_s[0]), .MEM_AWOUT(awout_s[1]), .IO_AWOUT(awout_s[2]),
      .ALU_WDATA(wdata_s[0]), .MEM_WDATA(wdata_s[1]), .IO_WDATA(wdata_s[2]),
      .ALU_RDATA(rdata_s[0]), .MEM_RDATA(rdata_s[1]), .IO_RDATA(rdata_s[2]),
      .ALU_RRESP(rresp[0]), .MEM_RRESP(rresp[1]), .IO_RRESP(rresp[2]),
      .ALU_BOUT(bout_s[0]), .MEM_BOUT(bout_s[1]), .IO_BOUT(bout_s[2])
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] op);
      en     = 1'b1;
      opcode = op;
      tick();
      en     = 1'b0;
      opcode = 8'h00;
   endtask

   task automatic check_all_zero(input string tag);
      for (int s = 0; s < 3; s++) begin
         check_eq(tag, {arvalid[s], rready[s], awvalid[s], wvalid[s], wlast[s], bready[s]}, 0);
         check_eq(tag, {out_s[s], awout_s[s]}, 0);
         check_eq(tag, {wdata_s[s], rdata_s[s], rresp[s], bout_s[s]}, 0);
      end
   endtask

   // Full read burst on slave s; beat i carries data base+i, last beat carries rresp=rr.
   task automatic do_read(input int s, input logic [3:0] id, input logic [7:0] base,
                          input logic rr);
      int n;
      n = 0;
      while (!arvalid[s] && n < 20) begin tick(); n++; end
      check_eq("ar_valid", 32'(arvalid[s]), 1);
      check_eq("ar_out", 32'(out_s[s]), 32'({id, 4'h3, id, 4'h0}));
      arready[s] = 1'b1;
      tick();
      arready[s] = 1'b0;
      check_eq("r_ready", 32'(rready[s]), 1);
      for (int i = 0; i < 4; i++) begin
         s_in[s]  = {(i == 3) ? rr : 1'b0, base + 8'(i)};
         rvalid[s] = 1'b1;
         rlast[s]  = (i == 3);
         tick();
      end
      rvalid[s] = 1'b0;
      rlast[s]  = 1'b0;
      check_eq("r_data", 32'(rdata_s[s]), 32'(base + 8'd3));
      check_eq("r_resp", 32'(rresp[s]), 32'(rr));
      check_eq("r_done", {arvalid[s], rready[s]}, 0);
   endtask

   task automatic do_write(input int s, input logic [3:0] id, input logic [4:0] br,
                           input logic [4:0] exp_bout);
      int n;
      n = 0;
      while (!awvalid[s] && n < 20) begin tick(); n++; end
      check_eq("aw_valid", 32'(awvalid[s]), 1);
      check_eq("aw_out", 32'(awout_s[s]), 32'({id, id, 4'h0}));
      awready[s] = 1'b1;
      tick();
      awready[s] = 1'b0;
      for (int b = 0; b < 4; b++) begin
         check_eq("w_valid", 32'(wvalid[s]), 1);
         check_eq("w_data", 32'(wdata_s[s]), 32'({id, 4'(b)}));
         check_eq("w_last", 32'(wlast[s]), 32'(b == 3));
         wready[s] = 1'b1;
         tick();
      end
      wready[s] = 1'b0;
      check_eq("b_ready", {wvalid[s], bready[s]}, 1);
      s_bresp[s] = br;
      bvalid[s]  = 1'b1;
      tick();
      bvalid[s]  = 1'b0;
      check_eq("b_out", 32'(bout_s[s]), 32'(exp_bout));
      check_eq("b_done", 32'(bready[s]), 0);
   endtask

   initial begin
      int n;
      rst = 1'b0; en = 1'b0; opcode = 8'h00;
      arready = '0; rvalid = '0; rlast = '0; awready = '0; wready = '0; bvalid = '0;
      ridle = '1; widle = '1; ridle_prev = '1; widle_prev = '1;
      for (int s = 0; s < 3; s++) begin s_in[s] = '0; s_bresp[s] = '0; end

      tick(); tick();
      check_all_zero("reset_hold");
      rst = 1'b1;
      tick();
      check_all_zero("reset_release");

      // ALU read ID 3.
      send(8'h34);
      do_read(0, 4'h3, 8'hA0, 1'b1);

      // MEM write ID 4, BID matches.
      send(8'h4A);
      do_write(1, 4'h4, 5'h08, 5'h08);

      // ALU write ID 3 answered with BID 4.
`ifdef CTRL_ID_CHECK_EN
      send(8'h36);
      do_write(0, 4'h3, 5'h08, 5'h09);
`else
      send(8'h36);
      do_write(0, 4'h3, 5'h08, 5'h08);
`endif

      // Back-to-back MEM reads complete in queue order.
      send(8'h48);
      send(8'h38);
      do_read(1, 4'h4, 8'h10, 1'b0);
      check_eq("b2b_gap", 32'(arvalid[1]), 0);
      do_read(1, 4'h3, 8'h20, 1'b0);

      // Queue overflow while MEM busy: fifth read dropped.
      ridle[1] = 1'b0; ridle_prev[1] = 1'b0;
      send(8'h18); send(8'h28); send(8'h38); send(8'h48); send(8'h58);
      tick();
      check_eq("busy_hold", 32'(arvalid[1]), 0);
      ridle[1] = 1'b1; ridle_prev[1] = 1'b1;
      for (int k = 1; k <= 4; k++) do_read(1, 4'(k), 8'(8'h30 + 8'(k << 4)), 1'b0);
      for (int k = 0; k < 5; k++) tick();
      check_eq("overflow_drop", 32'(arvalid[1]), 0);

      // Target 00 is discarded; IO read works.
      send(8'h70);
      for (int k = 0; k < 4; k++) tick();
      check_eq("discard", {arvalid, awvalid}, 0);
      send(8'h5C);
      do_read(2, 4'h5, 8'h60, 1'b1);

      // Reset mid write burst with another write queued: nothing resumes.
      send(8'h7A);
      send(8'h6A);
      n = 0;
      while (!awvalid[1] && n < 20) begin tick(); n++; end
      check_eq("mid_aw", 32'(awvalid[1]), 1);
      awready[1] = 1'b1;
      tick();
      awready[1] = 1'b0;
      check_eq("mid_w", 32'(wvalid[1]), 1);
      rst = 1'b0;
      #1;
      check_all_zero("mid_reset");
      tick();
      rst = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      check_eq("no_resume", {awvalid[1], wvalid[1], arvalid[1]}, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
